btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Conditions the raw board push-buttons (up, down, left, right) into clean, clock-synchronous control strobes for the game-logic stage. Each button is handled independently:
- a 2-flop synchronizer,
- a stability-counter debouncer,
- a one-shot press detector,
- an auto-repeat generator.

It sits between the board pins and the game logic. It drives that stage's debounced-level, single-clock-enable, multi-clock-enable and continuous-enable buses.

## Interface
- N_BTN, 4: number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a level change; must be ≥1.
- REPEAT_DELAY, 50_000_000: cycles from press acceptance to the first auto-repeat strobe; must be ≥1.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat strobes; must be ≥1.

- clk  in  1  system clock (100 MHz board clock).
- reset  in  1  asynchronous, active-high; clock clk.
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed. Bit mapping is {up, down, left, right} for N_BTN=4.
- dpb  out  N_BTN  debounced button level.
- scen  out  N_BTN  single-cycle strobe on accepted press.
- mcen  out  N_BTN  press strobe plus auto-repeat strobes while held.
- ccen  out  N_BTN  high every cycle the debounced button is held.

## Operation
The following applies per channel i; channels share no state.
- **Synchronizer:** s1 <= btn_in[i]; s2 <= s1. Only s2 is used downstream.
- **Debounce counter dc:**
  - width $clog2(DEBOUNCE_CYCLES)+1.
  - If s2 == dpb[i]: dc <= 0.
  - Else if dc == DEBOUNCE_CYCLES-1: dpb[i] <= s2 and dc <= 0.
  - Else: dc <= dc+1.
- **Press:** scen[i] is registered high for exactly the first cycle in which dpb[i] is 1 (the rising edge of dpb). It is low otherwise.
- **Release:** dpb falls through the same counter rule. No strobe is generated on release.
- **Auto-repeat:** let k = 0 be the first cycle with dpb[i] = 1.
  - mcen[i] is high at k = 0, k = REPEAT_DELAY, and k = REPEAT_DELAY + n·REPEAT_PERIOD (n ≥ 1), for as long as dpb[i] stays 1.
  - Implemented with a repeat counter rc that is cleared whenever dpb[i] = 0.
  - Phase states: IDLE (dpb=0), FIRST (counting to REPEAT_DELAY), REPEAT (counting REPEAT_PERIOD).
  - Transitions:
    - IDLE → FIRST on dpb rise.
    - FIRST → REPEAT at the first repeat strobe.
    - Any state → IDLE on dpb fall.
  - The counter saturates only by wrapping to 0 on each strobe. It never overflows: its width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD))+1.
- **ccen[i]:** equals dpb[i] (registered, same timing).
- **Glitches:** any excursion of s2 shorter than DEBOUNCE_CYCLES consecutive cycles produces no change on any output and restarts dc.
- **Reset:** all outputs, s1, s2, dc, rc and phase are forced to 0 / IDLE asynchronously.
  - A button held through reset deassertion is treated as a new press. It is accepted DEBOUNCE_CYCLES+2 edges later with a scen strobe.
  - Reset asserted mid-press or mid-repeat aborts immediately; no strobe appears in the reset cycle.
- **Simultaneous presses** on several channels produce simultaneous, independent strobes. No priority is applied.

## Timing
- **Press latency:** btn_in[i] is first sampled high at edge 1. s2 = 1 after edge 2. dpb, scen, mcen and ccen go high after edge DEBOUNCE_CYCLES+2.
- **Release latency:** DEBOUNCE_CYCLES+2 edges after the first edge sampling btn_in low.
- **Outputs:** every output is a flop output with no combinational path from btn_in.
- **Widths:** scen and mcen strobes are exactly one clk wide.
- **Repeat timing:** the minimum spacing between repeat strobes is REPEAT_PERIOD cycles. A release that is accepted on the same edge as a scheduled repeat strobe suppresses that strobe.

## Test plan
Use DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_BTN=4.
1. **Clean press/release.** btn_in[0] is set high before edge 1 and held for 100 cycles, then dropped.
   - dpb[0], ccen[0], scen[0] and mcen[0] rise after edge 10.
   - scen[0] is 1 for one cycle only.
   - dpb[0] falls 10 edges after the first low sample.
   - No strobe on release.
2. **Bounce rejection.** btn_in[1] toggles high for 7 cycles, low for 3, high for 7, then stays low.
   - All outputs of channel 1 remain 0 throughout.
3. **Auto-repeat.** btn_in[2] is held for 60 cycles after acceptance.
   - mcen[2] pulses at k = 0, 20, 25, 30, 35, 40, 45, 50, 55.
   - scen[2] pulses only at k = 0.
   - ccen[2] is high for all held cycles.
4. **Simultaneous buttons.** btn_in = 4'b1010 is applied on one edge.
   - scen = 4'b1010 for exactly one cycle, after edge 10.
   - Channels 0 and 2 remain 0.
5. **Reset mid-operation.** btn_in[3] is held. reset is asserted at k = 15, between clock edges, for 3 cycles, then released with btn_in[3] still high.
   - All outputs go to 0 immediately on reset assertion.
   - scen[3] fires again 10 edges after reset release.
6. **Press during repeat boundary.** btn_in[0] is released so that the dpb fall coincides with k = 25.
   - No mcen[0] strobe at k = 25.
   - All channel-0 outputs are 0 afterwards.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, stability-counter debouncer,
// one-shot press strobe and auto-repeat strobe generator. Channels share no state.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] dpb,
    output logic [N_BTN-1:0] scen,
    output logic [N_BTN-1:0] mcen,
    output logic [N_BTN-1:0] ccen
);

    localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DC_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RC_W   = $clog2(RC_MAX) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FIRST  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic            s1_q, s2_q;
        logic            dpb_q, dpb_d;
        logic            scen_q, scen_d;
        logic            mcen_q, mcen_d;
        logic            ccen_q;
        logic [DC_W-1:0] dc_q, dc_d;
        logic [RC_W-1:0] rc_q, rc_d;
        logic [1:0]      phase_q, phase_d;

        // Debouncer: accept s2 only after it differs from dpb for DEBOUNCE_CYCLES edges
        always_comb begin
            dpb_d = dpb_q;
            dc_d  = '0;
            if (s2_q != dpb_q) begin
                if (dc_q == DC_W'(DEBOUNCE_CYCLES - 1)) begin
                    dpb_d = s2_q;
                end else begin
                    dc_d = dc_q + DC_W'(1);
                end
            end
        end

        // Repeat phase FSM; strobes are keyed off the next dpb so all outputs move together
        always_comb begin
            phase_d = phase_q;
            rc_d    = rc_q;
            mcen_d  = 1'b0;
            scen_d  = dpb_d & ~dpb_q;
            case (phase_q)
                IDLE: begin
                    rc_d = '0;
                    if (dpb_d) begin
                        phase_d = FIRST;
                        mcen_d  = 1'b1;
                    end
                end
                FIRST: begin
                    if (rc_q == RC_W'(REPEAT_DELAY - 1)) begin
                        phase_d = REPEAT;
                        rc_d    = '0;
                        mcen_d  = 1'b1;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                REPEAT: begin
                    if (rc_q == RC_W'(REPEAT_PERIOD - 1)) begin
                        rc_d   = '0;
                        mcen_d = 1'b1;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                default: begin
                    phase_d = IDLE;
                    rc_d    = '0;
                end
            endcase
            // An accepted release wins over a repeat strobe scheduled on the same edge
            if (!dpb_d) begin
                phase_d = IDLE;
                rc_d    = '0;
                mcen_d  = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                dpb_q   <= 1'b0;
                dc_q    <= '0;
                scen_q  <= 1'b0;
                mcen_q  <= 1'b0;
                ccen_q  <= 1'b0;
                rc_q    <= '0;
                phase_q <= IDLE;
            end else begin
                s1_q    <= btn_in[i];
                s2_q    <= s1_q;
                dpb_q   <= dpb_d;
                dc_q    <= dc_d;
                scen_q  <= scen_d;
                mcen_q  <= mcen_d;
                ccen_q  <= dpb_d;
                rc_q    <= rc_d;
                phase_q <= phase_d;
            end
        end

        assign dpb[i]  = dpb_q;
        assign scen[i] = scen_q;
        assign mcen[i] = mcen_q;
        assign ccen[i] = ccen_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat parameters.
module tb_btn_conditioner;

    localparam int unsigned N_BTN = 4;
    localparam int unsigned DC    = 8;
    localparam int unsigned RD    = 20;
    localparam int unsigned RP    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] dpb, scen, mcen, ccen;

    int n_tests = 0;
    int n_fail  = 0;
    int scen_cnt [N_BTN];
    int mcen_cnt [N_BTN];
    int bad;

    btn_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn_in(btn_in),
        .dpb   (dpb),
        .scen  (scen),
        .mcen  (mcen),
        .ccen  (ccen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later and tally strobes
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < int'(N_BTN); c++) begin
            if (scen[c]) scen_cnt[c]++;
            if (mcen[c]) mcen_cnt[c]++;
        end
    endtask

    task automatic clear_cnt();
        for (int c = 0; c < int'(N_BTN); c++) begin
            scen_cnt[c] = 0;
            mcen_cnt[c] = 0;
        end
    endtask

    function automatic logic [3:0] ch(input int c);
        return {dpb[c], scen[c], mcen[c], ccen[c]};
    endfunction

    initial begin
        reset  = 1'b1;
        btn_in = '0;
        clear_cnt();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {16'h0, dpb, scen, mcen, ccen}, 32'h0);
        reset = 1'b0;
        repeat (3) tick();

        // 1: clean press/release on channel 0
        clear_cnt();
        btn_in = 4'b0001;
        repeat (9) tick();
        check("t1_before_accept", 32'(ch(0)), 32'h0);
        tick();
        check("t1_accept", 32'(ch(0)), 32'hF);
        tick();
        check("t1_scen_one_cycle", 32'(ch(0)), 32'h9);
        repeat (89) tick();
        btn_in = 4'b0000;
        repeat (9) tick();
        check("t1_before_release", 32'(dpb[0]), 32'h1);
        tick();
        check("t1_released", 32'(ch(0)), 32'h0);
        repeat (5) tick();
        check("t1_scen_count", 32'(scen_cnt[0]), 32'd1);
        check("t1_mcen_count", 32'(mcen_cnt[0]), 32'd17);

        // 2: bounce rejection on channel 1
        clear_cnt();
        bad = 0;
        btn_in = 4'b0010;
        for (int j = 0; j < 7; j++) begin tick(); if (ch(1) != 4'h0) bad++; end
        btn_in = 4'b0000;
        for (int j = 0; j < 3; j++) begin tick(); if (ch(1) != 4'h0) bad++; end
        btn_in = 4'b0010;
        for (int j = 0; j < 7; j++) begin tick(); if (ch(1) != 4'h0) bad++; end
        btn_in = 4'b0000;
        for (int j = 0; j < 20; j++) begin tick(); if (ch(1) != 4'h0) bad++; end
        check("t2_quiet_cycles", 32'(bad), 32'd0);
        check("t2_scen_count", 32'(scen_cnt[1]), 32'd0);

        // 3: auto-repeat on channel 2, k = cycles since acceptance
        btn_in = 4'b0100;
        repeat (10) tick();
        for (int k = 0; k < 60; k++) begin
            logic exp_m;
            if (k > 0) tick();
            exp_m = (k == 0) || (k == int'(RD)) || (k > int'(RD) && ((k - int'(RD)) % int'(RP)) == 0);
            check($sformatf("t3_k%0d", k), {29'h0, scen[2], mcen[2], ccen[2]},
                  {29'h0, (k == 0), exp_m, 1'b1});
        end
        btn_in = 4'b0000;
        repeat (10) tick();
        check("t3_released", 32'(ch(2)), 32'h0);

        // 4: simultaneous presses on channels 1 and 3
        btn_in = 4'b1010;
        repeat (9) tick();
        check("t4_before_accept", {28'h0, scen}, 32'h0);
        tick();
        check("t4_scen", {28'h0, scen}, 32'hA);
        check("t4_dpb", {28'h0, dpb}, 32'hA);
        tick();
        check("t4_scen_cleared", {28'h0, scen}, 32'h0);
        btn_in = 4'b0000;
        repeat (10) tick();
        check("t4_released", {28'h0, dpb}, 32'h0);

        // 5: reset mid-press on channel 3, button held across reset release
        btn_in = 4'b1000;
        repeat (10) tick();
        check("t5_accept", 32'(ch(3)), 32'hF);
        repeat (15) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t5_reset_clears", {16'h0, dpb, scen, mcen, ccen}, 32'h0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (9) tick();
        check("t5_before_reaccept", 32'(ch(3)), 32'h0);
        tick();
        check("t5_reaccept", 32'(ch(3)), 32'hF);
        btn_in = 4'b0000;
        repeat (10) tick();
        check("t5_released", 32'(ch(3)), 32'h0);

        // 6: release accepted exactly at the k = 25 repeat slot on channel 0
        clear_cnt();
        btn_in = 4'b0001;
        repeat (25) tick();
        btn_in = 4'b0000;
        repeat (9) tick();
        check("t6_k24", {30'h0, dpb[0], mcen[0]}, 32'h2);
        tick();
        check("t6_k25_suppressed", 32'(ch(0)), 32'h0);
        repeat (10) tick();
        check("t6_idle_after", 32'(ch(0)), 32'h0);
        check("t6_mcen_count", 32'(mcen_cnt[0]), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
